// File: rtl/mod_counter.sv
// Parametrised modulus counter with prescaler, clear, clamped parallel load,
// wrap/saturate terminal handling and registered wrap/load_clamp pulses.
module mod_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [64:0] MODULUS  = '0,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             ping,
    output logic             wrap,
    output logic             load_clamp
);

    localparam logic [64:0]       MOD_M1   = MODULUS - 65'd1;
    localparam logic [WIDTH-1:0]  TOP      = (MODULUS == 65'd0) ? {WIDTH{1'b1}} : MOD_M1[WIDTH-1:0];
    localparam int unsigned       PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre;
    logic [PW-1:0]    pre_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             clamp_nxt;
    logic             tick;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   dec;

    assign ping = up ? (count == TOP) : (count == '0);

    always_comb begin
        count_nxt = count;
        pre_nxt   = pre;
        wrap_nxt  = 1'b0;
        clamp_nxt = 1'b0;
        tick      = en && (pre == PRE_LAST);
        // One extra bit exposes the carry/borrow out of the terminal value.
        inc       = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
        dec       = {1'b0, count} - {{WIDTH{1'b0}}, 1'b1};

        if (clr) begin
            count_nxt = '0;
            pre_nxt   = '0;
        end else if (load) begin
            pre_nxt = '0;
            if (load_val > TOP) begin
                count_nxt = TOP;
                clamp_nxt = 1'b1;
            end else begin
                count_nxt = load_val;
            end
        end else if (en) begin
            pre_nxt = tick ? '0 : pre + PW'(1);
            if (tick) begin
                if (up) begin
                    if (inc > {1'b0, TOP}) begin
                        if (SATURATE) begin
                            count_nxt = TOP;
                        end else begin
                            count_nxt = '0;
                            wrap_nxt  = 1'b1;
                        end
                    end else begin
                        count_nxt = inc[WIDTH-1:0];
                    end
                end else begin
                    if (dec[WIDTH]) begin
                        if (SATURATE) begin
                            count_nxt = '0;
                        end else begin
                            count_nxt = TOP;
                            wrap_nxt  = 1'b1;
                        end
                    end else begin
                        count_nxt = dec[WIDTH-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            pre        <= '0;
            wrap       <= 1'b0;
            load_clamp <= 1'b0;
        end else begin
            count      <= count_nxt;
            pre        <= pre_nxt;
            wrap       <= wrap_nxt;
            load_clamp <= clamp_nxt;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Four mod_counter configurations driven by shared stimulus and checked
// every cycle against an arithmetic reference model, plus literal spot checks.
module tb_mod_counter;

    logic        clk = 1'b0;
    logic        rst, clr, en, up, load;
    logic [31:0] lv;

    always #5 clk = ~clk;

    // 0: W4 M10 P1 wrap   1: W3 sat   2: W4 M10 P3 wrap   3: defaults
    logic [3:0]  cnt_a, cnt_c;
    logic [2:0]  cnt_b;
    logic [31:0] cnt_d;
    logic [3:0]  ping_v, wrap_v, clamp_v;

    mod_counter #(.WIDTH(4), .MODULUS(65'd10), .SATURATE(1'b0), .PRESCALE(1)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
        .count(cnt_a), .ping(ping_v[0]), .wrap(wrap_v[0]), .load_clamp(clamp_v[0]));
    mod_counter #(.WIDTH(3), .MODULUS(65'd0), .SATURATE(1'b1), .PRESCALE(1)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load), .load_val(lv[2:0]),
        .count(cnt_b), .ping(ping_v[1]), .wrap(wrap_v[1]), .load_clamp(clamp_v[1]));
    mod_counter #(.WIDTH(4), .MODULUS(65'd10), .SATURATE(1'b0), .PRESCALE(3)) u_c (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
        .count(cnt_c), .ping(ping_v[2]), .wrap(wrap_v[2]), .load_clamp(clamp_v[2]));
    mod_counter u_d (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load), .load_val(lv),
        .count(cnt_d), .ping(ping_v[3]), .wrap(wrap_v[3]), .load_clamp(clamp_v[3]));

    logic [63:0] d_cnt [4];
    always_comb begin
        d_cnt[0] = 64'(cnt_a);
        d_cnt[1] = 64'(cnt_b);
        d_cnt[2] = 64'(cnt_c);
        d_cnt[3] = 64'(cnt_d);
    end

    longint unsigned tops [4] = '{64'd9, 64'd7, 64'd9, 64'hFFFF_FFFF};
    longint unsigned masks[4] = '{64'hF, 64'h7, 64'hF, 64'hFFFF_FFFF};
    longint unsigned pres [4] = '{64'd1, 64'd1, 64'd3, 64'd1};
    bit              sats [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    longint unsigned m_cnt [4];
    longint unsigned m_pre [4];
    bit              m_wrap[4];
    bit              m_clmp[4];

    int  total = 0;
    int  bad   = 0;
    bit  chk_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: the rules stated directly in integer arithmetic.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            longint unsigned v;
            if (rst || clr) begin
                m_cnt[k] = 0; m_pre[k] = 0; m_wrap[k] = 0; m_clmp[k] = 0;
            end else if (load) begin
                v = 64'(lv) & masks[k];
                m_clmp[k] = (v > tops[k]);
                m_cnt[k]  = m_clmp[k] ? tops[k] : v;
                m_pre[k]  = 0;
                m_wrap[k] = 0;
            end else begin
                m_wrap[k] = 0;
                m_clmp[k] = 0;
                if (en) begin
                    m_pre[k] = (m_pre[k] + 1) % pres[k];
                    if (m_pre[k] == 0) begin
                        if (up) begin
                            if (m_cnt[k] < tops[k]) m_cnt[k] = m_cnt[k] + 1;
                            else if (!sats[k]) begin m_cnt[k] = 0; m_wrap[k] = 1; end
                        end else begin
                            if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
                            else if (!sats[k]) begin m_cnt[k] = tops[k]; m_wrap[k] = 1; end
                        end
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            for (int k = 0; k < 4; k++) begin
                bit pexp;
                pexp = up ? (m_cnt[k] == tops[k]) : (m_cnt[k] == 0);
                chk($sformatf("model_count%0d", k), d_cnt[k], m_cnt[k]);
                chk($sformatf("model_ping%0d", k), 64'(ping_v[k]), 64'(pexp));
                chk($sformatf("model_wrap%0d", k), 64'(wrap_v[k]), 64'(m_wrap[k]));
                chk($sformatf("model_clamp%0d", k), 64'(clamp_v[k]), 64'(m_clmp[k]));
            end
        end
    end

    task automatic drive(input bit r, input bit c, input bit e, input bit u,
                         input bit l, input logic [31:0] v);
        @(negedge clk);
        rst = r; clr = c; en = e; up = u; load = l; lv = v;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; lv = '0;
        step();
        chk_on = 1'b1;
        chk("rst_cnt_a", 64'(cnt_a), 64'd0);
        chk("rst_cnt_d", 64'(cnt_d), 64'd0);
        chk("rst_wrap", 64'(wrap_v), 64'd0);
        chk("rst_clamp", 64'(clamp_v), 64'd0);

        drive(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("up_cnt_a", 64'(cnt_a), 64'((i + 1) % 10));
            chk("up_wrap_a", 64'(wrap_v[0]), 64'(i == 9));
            chk("up_ping_a", 64'(ping_v[0]), 64'(((i + 1) % 10) == 9));
        end
        chk("sat_top_b", 64'(cnt_b), 64'd7);
        chk("sat_nowrap_b", 64'(wrap_v[1]), 64'd0);
        chk("pres_cnt_c", 64'(cnt_c), 64'd4);
        chk("legacy_cnt_d", 64'(cnt_d), 64'd12);

        drive(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("sat_down_b", 64'(cnt_b), 64'((i <= 6) ? (6 - i) : 0));
        end
        chk("down_cnt_a", 64'(cnt_a), 64'd2);
        chk("down_cnt_c", 64'(cnt_c), 64'd1);
        chk("down_cnt_d", 64'(cnt_d), 64'd2);

        drive(0, 1, 1, 0, 0, 0);
        step();
        chk("clr_cnt_a", 64'(cnt_a), 64'd0);
        chk("clr_cnt_c", 64'(cnt_c), 64'd0);
        drive(0, 0, 1, 0, 0, 0);
        #1;
        chk("down_ping_a", 64'(ping_v[0]), 64'd1);
        step();
        chk("under_cnt_a", 64'(cnt_a), 64'd9);
        chk("under_wrap_a", 64'(wrap_v[0]), 64'd1);
        chk("under_sat_b", 64'(cnt_b), 64'd0);
        chk("under_cnt_d", 64'(cnt_d), 64'hFFFF_FFFF);
        chk("under_wrap_d", 64'(wrap_v[3]), 64'd1);

        drive(0, 1, 0, 1, 0, 0);
        step();
        begin
            bit pat [7] = '{1, 1, 0, 1, 1, 1, 1};
            for (int i = 0; i < 7; i++) begin
                drive(0, 0, pat[i], 1, 0, 0);
                step();
            end
        end
        chk("pres_seq_c", 64'(cnt_c), 64'd2);
        chk("pres_seq_a", 64'(cnt_a), 64'd6);

        drive(0, 1, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 1, 1, 32'd13);
        step();
        chk("load_clamp_cnt_a", 64'(cnt_a), 64'd9);
        chk("load_clamp_a", 64'(clamp_v[0]), 64'd1);
        chk("load_trunc_b", 64'(cnt_b), 64'd5);
        chk("load_noclamp_d", 64'(clamp_v[3]), 64'd0);
        drive(0, 0, 0, 1, 0, 0);
        step();
        chk("clamp_pulse_a", 64'(clamp_v[0]), 64'd0);
        drive(0, 0, 1, 1, 1, 32'd5);
        step();
        chk("load_tick_a", 64'(cnt_a), 64'd5);
        chk("load_tick_c", 64'(cnt_c), 64'd5);

        drive(0, 0, 0, 1, 1, 32'hFFFF_FFFE);
        step();
        chk("legacy_load_d", 64'(cnt_d), 64'hFFFF_FFFE);
        chk("legacy_noping_d", 64'(ping_v[3]), 64'd0);
        drive(0, 0, 1, 1, 0, 0);
        step();
        chk("legacy_ping_d", 64'(ping_v[3]), 64'd1);
        step();
        chk("legacy_wrap_cnt_d", 64'(cnt_d), 64'd0);
        chk("legacy_wrap_d", 64'(wrap_v[3]), 64'd1);
        step();
        step();
        drive(1, 1, 1, 1, 1, 32'd3);
        step();
        chk("rstclr_cnt_d", 64'(cnt_d), 64'd0);
        chk("rstclr_cnt_a", 64'(cnt_a), 64'd0);
        chk("rstclr_pulses", 64'({wrap_v, clamp_v}), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] v;
            v = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            drive($urandom_range(63) == 0, $urandom_range(31) == 0, $urandom_range(3) != 0,
                  $urandom_range(3) != 0, $urandom_range(7) == 0, v);
        end
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised successor to the fixed 32-bit free-running counter with an all-ones ping.
- Generalised in width, modulus, direction and prescale; adds synchronous clear, parallel load with range clamping, wrap/saturate mode and a registered wrap pulse.
- Used as a timebase/event counter in SAT and equivalence tests, and as a general-purpose counter in datapath blocks.

Parameters:
- WIDTH, 32, counter width in bits (1..64).
- MODULUS, 0, count range 0..MODULUS-1. 0 means full range 2^WIDTH. Legal values: 0 or 2..2^WIDTH.
- SATURATE, 0, 0 = wrap at terminal value; 1 = hold at terminal value.
- PRESCALE, 1, count advances once per PRESCALE enabled cycles (1..65536).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of count and prescaler.
- en  in  1  count enable; also gates the prescaler.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- ping  out  1  terminal flag, combinational from count and up.
- wrap  out  1  one-cycle registered pulse on a wrap event.
- load_clamp  out  1  one-cycle registered pulse when load_val was out of range.

Behaviour:
- TOP = 2^WIDTH-1 if MODULUS==0, else MODULUS-1.
- Reset: when rst=1 at posedge, count=0, prescaler=0, wrap=0, load_clamp=0.
- Priority per cycle: rst > clr > load > step.
- clr: count=0, prescaler=0, wrap=0, load_clamp=0.
- load:
  - count = load_val if load_val <= TOP, else TOP.
  - load_clamp=1 next cycle iff load_val > TOP.
  - prescaler=0; wrap=0.
  - A load in the same cycle as a tick suppresses the step.
- Prescaler:
  - Internal counter pre, width clog2(PRESCALE) (minimum 1).
  - When en=1: pre increments, and wraps to 0 after PRESCALE-1.
  - tick = en && (pre == PRESCALE-1). With PRESCALE=1, tick = en.
  - When en=0, pre holds.
- Step on tick, up=1:
  - count < TOP: count+1.
  - count == TOP: SATURATE=0 gives count=0 and wrap=1 next cycle; SATURATE=1 holds TOP with no wrap.
- Step on tick, up=0:
  - count > 0: count-1.
  - count == 0: SATURATE=0 gives count=TOP and wrap=1; SATURATE=1 holds 0.
- Arithmetic:
  - Computed in WIDTH+1 bits to detect terminal crossing.
  - No intermediate value above TOP is ever registered.
  - A count above TOP is unreachable.
- wrap and load_clamp are high for exactly one cycle per event; otherwise 0.
- ping = (up && count==TOP) || (!up && count==0). Changes immediately with up.
- Default parameters reproduce the legacy behaviour: count+1 per en cycle, ping = &count, 0xFFFFFFFF -> 0.
- Reset mid-prescale discards partial prescale progress.
- A direction change mid-prescale keeps pre.

Test Plan:
- WIDTH=4, MODULUS=10, PRESCALE=1; rst, then en=1, up=1 for 12 cycles -> count 0,1..9,0,1. ping high only at 9. wrap high the single cycle count shows 0 after 9.
- Same configuration, up=0 from count=0 -> count 9 next cycle, wrap=1, ping=1 while count=0 and up=0.
- SATURATE=1, WIDTH=3: count up from 0 for 10 cycles -> count sticks at 7, wrap never asserts. Switch up=0 -> 6,5,...,0 then holds 0.
- PRESCALE=3, en toggling 1,1,0,1,1,1,1 -> count increments only after the 3rd and 6th enabled cycles (value 2 after the sequence). en=0 holds pre.
- MODULUS=10, load with load_val=13 -> count=9, load_clamp=1 for one cycle. load with 5 alongside a tick -> count=5, no step.
- Defaults (WIDTH=32), load 0xFFFFFFFE, en=1 -> ping at 0xFFFFFFFF, then 0 with wrap=1. Assert rst and clr together mid-count -> count=0 next cycle, all pulses 0.
